sr_latch_driver: RTL and testbench

Synchronous front end and clocked replacement for the NOR set/reset latch. Two raw, asynchronous push-button inputs (set and reset) are synchronized, debounced, and edge-detected. The block produces single-cycle set/reset pulses and a registered Q/Qn pair that follows NOR-latch semantics, including the forbidden both-asserted condition. It sits between the board buttons and downstream logic that used to consume the combinational latch outputs.

---
 rtl/sr_latch_driver.sv | 157 +++++++++++++++
 tb/tb_sr_latch_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked replacement for a NOR set/reset latch.
// Each raw button input goes through a 2-flop synchronizer, a debounce counter
// and a rising-edge detector. A small FSM on the debounced levels produces
// registered Q/Qn with NOR-latch behaviour, including the both-asserted state.
// The race flag is sticky. It records a simultaneous exit from the forbidden state.

module sr_latch_driver #(
   parameter int DB_COUNT = 4,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic S_raw,
   input  logic R_raw,
   output logic Q,
   output logic Qn,
   output logic S_pulse,
   output logic R_pulse,
   output logic race
);

   typedef enum logic [1:0] {
      HOLD_RESET = 2'd0,
      HOLD_SET   = 2'd1,
      FORBIDDEN  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   logic             sSync1_q, sSync2_q, rSync1_q, rSync2_q;
   logic [CNT_W-1:0] sCnt_q, sCnt_d, rCnt_q, rCnt_d;
   logic             sDb_q, sDb_d, rDb_q, rDb_d;
   logic             sDbPrev_q, rDbPrev_q;
   logic             sPulse_q, rPulse_q;
   state_e           state_q, state_d;
   logic             race_q, race_d;

   // Set channel debounce: the level moves only after sync2 disagrees for DB_COUNT edges in a row
   always_comb begin
      sCnt_d = sCnt_q;
      sDb_d  = sDb_q;
      if (sSync2_q == sDb_q) begin
         sCnt_d = '0;
      end else if (sCnt_q == CNT_LAST) begin
         sDb_d  = sSync2_q;
         sCnt_d = '0;
      end else begin
         sCnt_d = sCnt_q + CNT_W'(1);
      end
   end

   // Reset channel debounce, identical to the set channel
   always_comb begin
      rCnt_d = rCnt_q;
      rDb_d  = rDb_q;
      if (rSync2_q == rDb_q) begin
         rCnt_d = '0;
      end else if (rCnt_q == CNT_LAST) begin
         rDb_d  = rSync2_q;
         rCnt_d = '0;
      end else begin
         rCnt_d = rCnt_q + CNT_W'(1);
      end
   end

   // Front-end registers: synchronizers, debounce state, previous levels and edge pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sSync1_q  <= 1'b0;
         sSync2_q  <= 1'b0;
         rSync1_q  <= 1'b0;
         rSync2_q  <= 1'b0;
         sCnt_q    <= '0;
         rCnt_q    <= '0;
         sDb_q     <= 1'b0;
         rDb_q     <= 1'b0;
         sDbPrev_q <= 1'b0;
         rDbPrev_q <= 1'b0;
         sPulse_q  <= 1'b0;
         rPulse_q  <= 1'b0;
      end else begin
         sSync1_q  <= S_raw;
         sSync2_q  <= sSync1_q;
         rSync1_q  <= R_raw;
         rSync2_q  <= rSync1_q;
         sCnt_q    <= sCnt_d;
         rCnt_q    <= rCnt_d;
         sDb_q     <= sDb_d;
         rDb_q     <= rDb_d;
         sDbPrev_q <= sDb_q;
         rDbPrev_q <= rDb_q;
         sPulse_q  <= sDb_q & ~sDbPrev_q;
         rPulse_q  <= rDb_q & ~rDbPrev_q;
      end
   end

   // Latch state register and the sticky race flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD_RESET;
         race_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         race_q  <= race_d;
      end
   end

   // Next-state logic on the debounced levels; a both-low exit from FORBIDDEN raises race
   always_comb begin
      state_d = state_q;
      race_d  = race_q;
      case (state_q)
         HOLD_RESET: begin
            if (sDb_q & rDb_q)       state_d = FORBIDDEN;
            else if (sDb_q)          state_d = HOLD_SET;
         end
         HOLD_SET: begin
            if (sDb_q & rDb_q)       state_d = FORBIDDEN;
            else if (rDb_q)          state_d = HOLD_RESET;
         end
         FORBIDDEN: begin
            if (sDb_q & ~rDb_q)      state_d = HOLD_SET;
            else if (rDb_q & ~sDb_q) state_d = HOLD_RESET;
            else if (~sDb_q & ~rDb_q) begin
               state_d = HOLD_RESET;
               race_d  = 1'b1;
            end
         end
         default: state_d = HOLD_RESET;
      endcase
   end

   // Output decode from the state register only, so Q/Qn never see the inputs combinationally
   always_comb begin
      Q  = 1'b0;
      Qn = 1'b1;
      case (state_q)
         HOLD_SET: begin
            Q  = 1'b1;
            Qn = 1'b0;
         end
         FORBIDDEN: begin
            Q  = 1'b0;
            Qn = 1'b0;
         end
         default: begin
            Q  = 1'b0;
            Qn = 1'b1;
         end
      endcase
   end

   assign S_pulse = sPulse_q;
   assign R_pulse = rPulse_q;
   assign race    = race_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed vectors for sr_latch_driver with DB_COUNT=4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the same
// point, so each check sees the result of the edge just taken.

module tb_sr_latch_driver;

   logic clk;
   logic rst;
   logic S_raw;
   logic R_raw;
   logic Q;
   logic Qn;
   logic S_pulse;
   logic R_pulse;
   logic race;

   int vectorCount;
   int missCount;

   sr_latch_driver #(
      .DB_COUNT (4),
      .CNT_W    (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .S_raw   (S_raw),
      .R_raw   (R_raw),
      .Q       (Q),
      .Qn      (Qn),
      .S_pulse (S_pulse),
      .R_pulse (R_pulse),
      .race    (race)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges and settle just past each one
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r);
      S_raw = s;
      R_raw = r;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %b, expected %b at time %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkState(input string tag, input logic eQ, input logic eQn,
                             input logic eSp, input logic eRp, input logic eRace);
      checkOutput({tag, ".Q"},       Q,       eQ);
      checkOutput({tag, ".Qn"},      Qn,      eQn);
      checkOutput({tag, ".S_pulse"}, S_pulse, eSp);
      checkOutput({tag, ".R_pulse"}, R_pulse, eRp);
      checkOutput({tag, ".race"},    race,    eRace);
   endtask

   // Release both buttons and let the debounced levels fall, checking that nothing moves
   task automatic releaseAndSettle(input string tag, input logic eQ, input logic eQn, input logic eRace);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         checkState(tag, eQ, eQn, 1'b0, 1'b0, eRace);
      end
   endtask

   initial begin
      vectorCount = 0;
      missCount   = 0;
      rst         = 1'b1;
      applyStimulus(1'b0, 1'b0);

      tick(2);
      checkState("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // A 3-cycle glitch is shorter than the debounce window
      applyStimulus(1'b1, 1'b0);
      tick(3);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick(1);
         checkState("glitch", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Clean set: sampled at edge k, visible at k+6 only
      applyStimulus(1'b1, 1'b0);
      tick(6);
      checkState("set_k5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkState("set_k6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1);
      checkState("set_k7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      releaseAndSettle("set_rel", 1'b1, 1'b0, 1'b0);

      // Reset from HOLD_SET
      applyStimulus(1'b0, 1'b1);
      tick(6);
      checkState("rst_k5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkState("rst_k6", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      checkState("rst_k7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      releaseAndSettle("rst_rel", 1'b0, 1'b1, 1'b0);

      // Bounce: high 3, low 1, then held; only the final rise qualifies
      applyStimulus(1'b1, 1'b0);
      tick(3);
      applyStimulus(1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checkState("bounce_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick(1);
      checkState("bounce_k6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      releaseAndSettle("bounce_rel", 1'b1, 1'b0, 1'b0);

      // Reset mid-debounce with S held: full requalification afterwards
      applyStimulus(1'b1, 1'b0);
      tick(3);
      rst = 1'b1;
      tick(2);
      checkState("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checkState("midrst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick(1);
      checkState("midrst_k6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      releaseAndSettle("midrst_rel", 1'b1, 1'b0, 1'b0);

      // Forbidden, staggered exit: release R first
      applyStimulus(1'b1, 1'b1);
      tick(6);
      checkState("forb_k5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkState("forb_k6", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1);
      checkState("forb_k7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      tick(6);
      checkState("stag_k5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkState("stag_k6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      releaseAndSettle("stag_rel", 1'b1, 1'b0, 1'b0);

      // Forbidden, simultaneous exit raises the sticky race flag
      applyStimulus(1'b1, 1'b1);
      tick(7);
      checkState("sim_forb", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      tick(6);
      checkState("sim_k5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkState("sim_k6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // race survives later set/reset activity
      applyStimulus(1'b1, 1'b0);
      tick(7);
      checkState("race_set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      releaseAndSettle("race_set_rel", 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      tick(7);
      checkState("race_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      releaseAndSettle("race_rst_rel", 1'b0, 1'b1, 1'b1);

      // Only rst clears race
      rst = 1'b1;
      tick(1);
      checkState("race_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
